// File: rtl/parking_pkg.sv
// Shared types and defaults for the parking system.
// Used by the gate controller, slot finder and display.
package parking_pkg;

  typedef enum logic {
    IDLE,
    OPEN
  } gate_state_e;

  typedef enum logic {
    DIR_ENTRY,
    DIR_EXIT
  } dir_e;

  localparam int unsigned CAPACITY_DEF         = 8;
  localparam int unsigned GATE_OPEN_CYCLES_DEF = 80_000_000;

endpackage

// File: rtl/parking_slot_finder.sv
// Lowest-index free slot finder over the occupancy map.
// Purely combinational priority encoder.
module parking_slot_finder #(
  parameter  int unsigned CAPACITY = 8,
  localparam int unsigned SLOT_W   = $clog2(CAPACITY)
) (
  input  logic [CAPACITY-1:0] occupancy_i,
  output logic [SLOT_W-1:0]   free_idx_o,
  output logic                any_free_o
);

  // scan downward so the lowest free index is written last
  always_comb begin
    free_idx_o = '0;
    any_free_o = 1'b0;
    for (int i = CAPACITY - 1; i >= 0; i--) begin
      if (!occupancy_i[i]) begin
        free_idx_o = SLOT_W'(i);
        any_free_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/parking_gate_controller.sv
// Shared barrier gate sequencer and slot allocator.
// Arbitrates entry/exit requests with alternating priority.
module parking_gate_controller
  import parking_pkg::*;
#(
  parameter  int unsigned CAPACITY         = CAPACITY_DEF,
  parameter  int unsigned GATE_OPEN_CYCLES = GATE_OPEN_CYCLES_DEF,
  localparam int unsigned SLOT_W           = $clog2(CAPACITY)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                entry_pulse,
  input  logic                exit_pulse,
  input  logic [SLOT_W-1:0]   exit_slot,
  output logic                entry_gate_open,
  output logic                exit_gate_open,
  output logic [SLOT_W-1:0]   assigned_slot,
  output logic                assigned_valid,
  output logic                reject_pulse,
  output logic [CAPACITY-1:0] occupancy,
  output logic [SLOT_W:0]     free_count,
  output logic                full
);

  localparam int unsigned TW = $clog2(GATE_OPEN_CYCLES) + 1;
  localparam int unsigned FW = SLOT_W + 1;
  localparam logic [TW-1:0] TLOAD = TW'(GATE_OPEN_CYCLES - 1);
  localparam logic [FW-1:0] CAP_W = FW'(CAPACITY);

  gate_state_e         state_q;
  dir_e                last_grant_q;
  logic                pend_entry_q;
  logic                pend_exit_q;
  logic [SLOT_W-1:0]   pend_slot_q;
  logic [TW-1:0]       timer_q;
  logic                entry_gate_q;
  logic                exit_gate_q;
  logic [SLOT_W-1:0]   assigned_slot_q;
  logic                assigned_valid_q;
  logic                reject_q;
  logic [CAPACITY-1:0] occ_q;
  logic [FW-1:0]       free_count_q;
  logic                full_q;

  logic [SLOT_W-1:0]   free_idx;
  logic                any_free;
  logic                pick_entry;
  logic                pick_exit;
  logic [CAPACITY-1:0] free_mask;
  logic [CAPACITY-1:0] exit_mask;
  logic                exit_ok;

  parking_slot_finder #(
    .CAPACITY (CAPACITY)
  ) u_finder (
    .occupancy_i (occ_q),
    .free_idx_o  (free_idx),
    .any_free_o  (any_free)
  );

  // arbitration: lone request wins, ties alternate on last_grant
  always_comb begin
    pick_entry = 1'b0;
    pick_exit  = 1'b0;
    if (state_q == IDLE) begin
      if (pend_entry_q && pend_exit_q) begin
        if (last_grant_q == DIR_EXIT) pick_entry = 1'b1;
        else                          pick_exit  = 1'b1;
      end else if (pend_entry_q) begin
        pick_entry = 1'b1;
      end else if (pend_exit_q) begin
        pick_exit = 1'b1;
      end
    end
  end

  // slot masks and exit validity (out-of-range slots never match)
  always_comb begin
    free_mask = CAPACITY'(1) << free_idx;
    exit_mask = CAPACITY'(1) << pend_slot_q;
    exit_ok   = ({1'b0, pend_slot_q} < CAP_W) && (|(occ_q & exit_mask));
  end

  // request latching, gate FSM and all registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q          <= IDLE;
      last_grant_q     <= DIR_EXIT;
      pend_entry_q     <= 1'b0;
      pend_exit_q      <= 1'b0;
      pend_slot_q      <= '0;
      timer_q          <= '0;
      entry_gate_q     <= 1'b0;
      exit_gate_q      <= 1'b0;
      assigned_slot_q  <= '0;
      assigned_valid_q <= 1'b0;
      reject_q         <= 1'b0;
      occ_q            <= '0;
      free_count_q     <= CAP_W;
      full_q           <= 1'b0;
    end else begin
      assigned_valid_q <= 1'b0;
      reject_q         <= 1'b0;

      if (entry_pulse && !pend_entry_q) pend_entry_q <= 1'b1;
      else if (pick_entry)              pend_entry_q <= 1'b0;

      if (exit_pulse && !pend_exit_q) begin
        pend_exit_q <= 1'b1;
        pend_slot_q <= exit_slot;
      end else if (pick_exit) begin
        pend_exit_q <= 1'b0;
      end

      unique case (state_q)
        IDLE: begin
          if (pick_entry) begin
            if (!any_free) begin
              reject_q <= 1'b1;
            end else begin
              occ_q            <= occ_q | free_mask;
              free_count_q     <= free_count_q - FW'(1);
              full_q           <= (free_count_q == FW'(1));
              assigned_slot_q  <= free_idx;
              assigned_valid_q <= 1'b1;
              last_grant_q     <= DIR_ENTRY;
              entry_gate_q     <= 1'b1;
              timer_q          <= TLOAD;
              state_q          <= OPEN;
            end
          end else if (pick_exit) begin
            if (!exit_ok) begin
              reject_q <= 1'b1;
            end else begin
              occ_q        <= occ_q & ~exit_mask;
              free_count_q <= free_count_q + FW'(1);
              full_q       <= 1'b0;
              last_grant_q <= DIR_EXIT;
              exit_gate_q  <= 1'b1;
              timer_q      <= TLOAD;
              state_q      <= OPEN;
            end
          end
        end
        OPEN: begin
          if (timer_q == '0) begin
            entry_gate_q <= 1'b0;
            exit_gate_q  <= 1'b0;
            state_q      <= IDLE;
          end else begin
            timer_q <= timer_q - TW'(1);
          end
        end
      endcase
    end
  end

  assign entry_gate_open = entry_gate_q;
  assign exit_gate_open  = exit_gate_q;
  assign assigned_slot   = assigned_slot_q;
  assign assigned_valid  = assigned_valid_q;
  assign reject_pulse    = reject_q;
  assign occupancy       = occ_q;
  assign free_count      = free_count_q;
  assign full            = full_q;

endmodule

// File: tb/tb_parking_gate_controller.sv
// Directed bench for parking_gate_controller.
// CAPACITY=4, GATE_OPEN_CYCLES=4.
module tb_parking_gate_controller;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       entry_pulse;
  logic       exit_pulse;
  logic [1:0] exit_slot;
  logic       entry_gate_open;
  logic       exit_gate_open;
  logic [1:0] assigned_slot;
  logic       assigned_valid;
  logic       reject_pulse;
  logic [3:0] occupancy;
  logic [2:0] free_count;
  logic       full;

  int vectors = 0;
  int miscompares = 0;

  parking_gate_controller #(
    .CAPACITY         (4),
    .GATE_OPEN_CYCLES (4)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .entry_pulse     (entry_pulse),
    .exit_pulse      (exit_pulse),
    .exit_slot       (exit_slot),
    .entry_gate_open (entry_gate_open),
    .exit_gate_open  (exit_gate_open),
    .assigned_slot   (assigned_slot),
    .assigned_valid  (assigned_valid),
    .reject_pulse    (reject_pulse),
    .occupancy       (occupancy),
    .free_count      (free_count),
    .full            (full)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(string tag, logic obs, logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic snap(string tag, logic eg, logic xg, logic [1:0] sl,
                      logic av, logic rj, logic [3:0] oc,
                      logic [2:0] fc, logic fu);
    chk1({tag, ".entry_gate"}, entry_gate_open, eg);
    chk1({tag, ".exit_gate"}, exit_gate_open, xg);
    vectors++;
    assert (assigned_slot === sl) else begin
      miscompares++;
      $error("FAIL %s.slot observed=%0d expected=%0d", tag, assigned_slot, sl);
    end
    chk1({tag, ".valid"}, assigned_valid, av);
    chk1({tag, ".reject"}, reject_pulse, rj);
    vectors++;
    assert (occupancy === oc) else begin
      miscompares++;
      $error("FAIL %s.occ observed=%b expected=%b", tag, occupancy, oc);
    end
    vectors++;
    assert (free_count === fc) else begin
      miscompares++;
      $error("FAIL %s.free observed=%0d expected=%0d", tag, free_count, fc);
    end
    chk1({tag, ".full"}, full, fu);
  endtask

  // gate already seen high once; expect 3 more high cycles, then low
  task automatic open_window(string tag, logic eg, logic xg);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk1($sformatf("%s.hi%0d.eg", tag, i), entry_gate_open, eg);
      chk1($sformatf("%s.hi%0d.xg", tag, i), exit_gate_open, xg);
      chk1($sformatf("%s.hi%0d.strobe", tag, i),
           assigned_valid | reject_pulse, 1'b0);
    end
    tick();
    chk1({tag, ".close.eg"}, entry_gate_open, 1'b0);
    chk1({tag, ".close.xg"}, exit_gate_open, 1'b0);
  endtask

  task automatic entry_grant(string tag, logic [1:0] sl, logic [3:0] oc,
                             logic [2:0] fc, logic fu);
    entry_pulse = 1'b1;
    tick();
    entry_pulse = 1'b0;
    chk1({tag, ".n1_valid"}, assigned_valid, 1'b0);
    tick();
    snap(tag, 1'b1, 1'b0, sl, 1'b1, 1'b0, oc, fc, fu);
    open_window(tag, 1'b1, 1'b0);
  endtask

  task automatic exit_grant(string tag, logic [1:0] s, logic [1:0] sl,
                            logic [3:0] oc, logic [2:0] fc);
    exit_pulse = 1'b1;
    exit_slot  = s;
    tick();
    exit_pulse = 1'b0;
    tick();
    snap(tag, 1'b0, 1'b1, sl, 1'b0, 1'b0, oc, fc, 1'b0);
    open_window(tag, 1'b0, 1'b1);
  endtask

  initial begin
    logic [2:0] far_slot;
    logic       seen;
    reset_n     = 1'b0;
    entry_pulse = 1'b0;
    exit_pulse  = 1'b0;
    exit_slot   = 2'd0;
    tick();
    tick();
    snap("reset", 0, 0, 2'd0, 0, 0, 4'b0000, 3'd4, 0);
    reset_n = 1'b1;
    tick();

    entry_grant("ent0", 2'd0, 4'b0001, 3'd3, 1'b0);
    entry_grant("ent1", 2'd1, 4'b0011, 3'd2, 1'b0);
    entry_grant("ent2", 2'd2, 4'b0111, 3'd1, 1'b0);
    entry_grant("ent3", 2'd3, 4'b1111, 3'd0, 1'b1);

    entry_pulse = 1'b1;
    tick();
    entry_pulse = 1'b0;
    tick();
    snap("ent_full", 0, 0, 2'd3, 0, 1, 4'b1111, 3'd0, 1);
    tick();
    chk1("ent_full.rej_1cyc", reject_pulse, 1'b0);

    exit_grant("exit2", 2'd2, 2'd3, 4'b1011, 3'd1);
    entry_grant("reuse2", 2'd2, 4'b1111, 3'd0, 1'b1);
    exit_grant("exit0", 2'd0, 2'd2, 4'b1110, 3'd1);

    entry_pulse = 1'b1;
    exit_pulse  = 1'b1;
    exit_slot   = 2'd3;
    tick();
    entry_pulse = 1'b0;
    exit_pulse  = 1'b0;
    tick();
    snap("sim_ent", 1, 0, 2'd0, 1, 0, 4'b1111, 3'd0, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk1($sformatf("sim_ent.hi%0d.eg", i), entry_gate_open, 1'b1);
      chk1($sformatf("sim_ent.hi%0d.xg", i), exit_gate_open, 1'b0);
    end
    tick();
    snap("sim_gap", 0, 0, 2'd0, 0, 0, 4'b1111, 3'd0, 1);
    tick();
    snap("sim_exit", 0, 1, 2'd0, 0, 0, 4'b0111, 3'd1, 0);
    open_window("sim_exit", 1'b0, 1'b1);

    exit_grant("exit1", 2'd1, 2'd0, 4'b0101, 3'd2);

    exit_pulse = 1'b1;
    exit_slot  = 2'd1;
    tick();
    exit_pulse = 1'b0;
    tick();
    snap("rej_empty", 0, 0, 2'd0, 0, 1, 4'b0101, 3'd2, 0);
    tick();

    far_slot   = 3'd5;
    exit_pulse = 1'b1;
    exit_slot  = far_slot[1:0];
    tick();
    exit_pulse = 1'b0;
    tick();
    snap("rej_far", 0, 0, 2'd0, 0, 1, 4'b0101, 3'd2, 0);
    tick();

    entry_pulse = 1'b1;
    tick();
    entry_pulse = 1'b0;
    tick();
    snap("mid_grant", 1, 0, 2'd1, 1, 0, 4'b0111, 3'd1, 0);
    exit_pulse = 1'b1;
    exit_slot  = 2'd0;
    tick();
    exit_pulse = 1'b0;
    reset_n    = 1'b0;
    #1;
    snap("mid_rst", 0, 0, 2'd0, 0, 0, 4'b0000, 3'd4, 0);
    tick();
    reset_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      seen = seen | entry_gate_open | exit_gate_open | assigned_valid
           | reject_pulse | (|occupancy);
    end
    chk1("post_rst_quiet", seen, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
